// File: rtl/avg_alarm_monitor.sv
`default_nettype none
// ============================================================================
// Module      : avg_alarm_monitor
// Description : Debounced, hysteretic threshold alarm on the averaged sample
//               stream. Tracks the peak average per alarm episode and keeps a
//               saturating count of alarm entries.
//               Optional build macro AVG_ALARM_STICKY_EN: the alarm latches
//               until alarm_ack instead of clearing on low samples.
// Revision    : 1.0 - initial release
// ============================================================================
module avg_alarm_monitor #(
  parameter int W             = 16,
  parameter int PERSIST       = 3,
  parameter int CLEAR_PERSIST = 3,
  parameter int HOLDOFF       = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] avg_in,
  input  logic         avg_valid,
  input  logic [W-1:0] thr_hi,
  input  logic [W-1:0] thr_lo,
  input  logic         alarm_ack,
  output logic         alarm,
  output logic         alarm_rise,
  output logic [1:0]   state,
  output logic [W-1:0] peak,
  output logic [7:0]   alarm_count
);

  localparam int CNT_MAX = (PERSIST > CLEAR_PERSIST) ? PERSIST : CLEAR_PERSIST;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int HCNT_W  = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  // The run counters compare against "one short" so the sample that completes
  // the run triggers the transition in the same cycle it is accepted.
  localparam logic [CNT_W-1:0]  C_RAISE_LAST = CNT_W'(PERSIST - 1);
  localparam logic [CNT_W-1:0]  C_CLEAR_LAST = CNT_W'(CLEAR_PERSIST - 1);
  localparam logic [HCNT_W-1:0] C_HOLD_LAST  = HCNT_W'(HOLDOFF - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MONITOR = 2'd1,
    S_ALARM   = 2'd2,
    S_HOLDOFF = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [HCNT_W-1:0]  hcnt_q, hcnt_d;
  logic               alarm_q, alarm_d;
  logic               rise_q, rise_d;
  logic [W-1:0]       peak_q, peak_d;
  logic [7:0]         count_q, count_d;

  logic w_hi;
  logic w_lo_run;
  logic w_clear;

  assign w_hi = (avg_in > thr_hi);

`ifdef AVG_ALARM_STICKY_EN
  // Latched alarm: only the acknowledge releases it, low samples never count.
  logic w_unused_thr_lo;
  assign w_unused_thr_lo = ^thr_lo;
  assign w_lo_run        = 1'b0;
  assign w_clear         = alarm_ack;
`else
  // Self-clearing alarm: a run of CLEAR_PERSIST low samples releases it.
  logic w_lo;
  logic w_unused_ack;
  assign w_unused_ack = alarm_ack;
  assign w_lo         = (avg_in < thr_lo);
  assign w_lo_run     = avg_valid & w_lo;
  assign w_clear      = w_lo_run & (cnt_q == C_CLEAR_LAST);
`endif

  // Next-state and next-output computation for the alarm FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hcnt_d  = hcnt_q;
    alarm_d = alarm_q;
    rise_d  = 1'b0;
    peak_d  = peak_q;
    count_d = count_q;

    case (state_q)
      // IDLE evaluates its first sample exactly like MONITOR; cnt is 0 here.
      S_IDLE, S_MONITOR: begin
        if (avg_valid) begin
          state_d = S_MONITOR;
          if (w_hi) begin
            if (cnt_q == C_RAISE_LAST) begin
              state_d = S_ALARM;
              alarm_d = 1'b1;
              rise_d  = 1'b1;
              peak_d  = avg_in;
              cnt_d   = '0;
              if (count_q != 8'hFF) begin
                count_d = count_q + 8'd1;
              end
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            cnt_d = '0;
          end
        end
      end

      S_ALARM: begin
        if (avg_valid && (avg_in > peak_q)) begin
          peak_d = avg_in;
        end
        if (w_clear) begin
          state_d = S_HOLDOFF;
          alarm_d = 1'b0;
          cnt_d   = '0;
          hcnt_d  = '0;
        end else if (avg_valid) begin
          cnt_d = w_lo_run ? (cnt_q + 1'b1) : '0;
        end
      end

      // Time-based lockout; samples are ignored regardless of avg_valid.
      S_HOLDOFF: begin
        if (hcnt_q == C_HOLD_LAST) begin
          state_d = S_MONITOR;
          cnt_d   = '0;
          hcnt_d  = '0;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any episode without a pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hcnt_q  <= '0;
      alarm_q <= 1'b0;
      rise_q  <= 1'b0;
      peak_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hcnt_q  <= hcnt_d;
      alarm_q <= alarm_d;
      rise_q  <= rise_d;
      peak_q  <= peak_d;
      count_q <= count_d;
    end
  end

  assign alarm       = alarm_q;
  assign alarm_rise  = rise_q;
  assign state       = state_q;
  assign peak        = peak_q;
  assign alarm_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_avg_alarm_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_avg_alarm_monitor
// Description : Self-checking bench for avg_alarm_monitor: directed vector
//               table, alarm-count saturation sequence, and randomized
//               stimulus against a behavioural reference model.
//               Honours AVG_ALARM_STICKY_EN when the design is built with it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_avg_alarm_monitor;

  localparam int W             = 16;
  localparam int PERSIST       = 3;
  localparam int CLEAR_PERSIST = 3;
  localparam int HOLDOFF       = 8;

`ifdef AVG_ALARM_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] avg_in;
  logic         avg_valid;
  logic [W-1:0] thr_hi;
  logic [W-1:0] thr_lo;
  logic         alarm_ack;
  logic         alarm;
  logic         alarm_rise;
  logic [1:0]   state;
  logic [W-1:0] peak;
  logic [7:0]   alarm_count;

  always #5 clk = ~clk;

  avg_alarm_monitor #(
    .W(W), .PERSIST(PERSIST), .CLEAR_PERSIST(CLEAR_PERSIST), .HOLDOFF(HOLDOFF)
  ) dut (
    .clk(clk), .rst(rst), .avg_in(avg_in), .avg_valid(avg_valid),
    .thr_hi(thr_hi), .thr_lo(thr_lo), .alarm_ack(alarm_ack),
    .alarm(alarm), .alarm_rise(alarm_rise), .state(state),
    .peak(peak), .alarm_count(alarm_count)
  );

  int checks   = 0;
  int failures = 0;

  // ------------------------------------------------------------------------
  // Reference model: alarm episodes described with plain integers. Holdoff
  // is tracked as an absolute edge number at which monitoring resumes.
  // ------------------------------------------------------------------------
  int     m_state = 0;   // 0 idle, 1 monitor, 2 alarm, 3 holdoff
  int     m_run   = 0;
  int     m_peak  = 0;
  int     m_count = 0;
  bit     m_alarm = 0;
  bit     m_rise  = 0;
  longint m_edge  = 0;
  longint m_hold_end = 0;

  function automatic void model_leave_alarm();
    m_state    = 3;
    m_alarm    = 0;
    m_run      = 0;
    m_hold_end = m_edge + HOLDOFF;
  endfunction

  function automatic void model_step(bit r, bit v, int a, int hi, int lo, bit ack);
    m_edge++;
    m_rise = 0;
    if (r) begin
      m_state = 0; m_run = 0; m_peak = 0; m_count = 0; m_alarm = 0;
      return;
    end
    if (m_state == 3) begin
      if (m_edge == m_hold_end) begin
        m_state = 1;
        m_run   = 0;
      end
      return;
    end
    if (m_state == 2) begin
      if (v && a > m_peak) m_peak = a;
      if (STICKY) begin
        if (ack) model_leave_alarm();
      end else if (v) begin
        m_run = (a < lo) ? m_run + 1 : 0;
        if (m_run == CLEAR_PERSIST) model_leave_alarm();
      end
      return;
    end
    if (!v) return;
    m_state = 1;
    m_run   = (a > hi) ? m_run + 1 : 0;
    if (m_run == PERSIST) begin
      m_state = 2;
      m_alarm = 1;
      m_rise  = 1;
      m_peak  = a;
      m_count = (m_count < 255) ? m_count + 1 : 255;
      m_run   = 0;
    end
  endfunction

  // Apply one cycle of inputs, advance the model, and move just past the edge.
  task automatic drive(input bit r, input bit v, input logic [W-1:0] a, input bit ack);
    rst       = r;
    avg_valid = v;
    avg_in    = a;
    alarm_ack = ack;
    model_step(r, v, int'(a), int'(thr_hi), int'(thr_lo), ack);
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string tag, input int idx,
                               input logic ea, input logic er, input logic [1:0] es,
                               input logic [W-1:0] ep, input logic [7:0] ec);
    checks++;
    if ({alarm, alarm_rise, state, peak, alarm_count} !== {ea, er, es, ep, ec}) begin
      failures++;
      $display("FAIL %s[%0d]: got alarm=%0b rise=%0b state=%0d peak=%h count=%0d, want alarm=%0b rise=%0b state=%0d peak=%h count=%0d",
               tag, idx, alarm, alarm_rise, state, peak, alarm_count, ea, er, es, ep, ec);
    end
  endtask

  // ------------------------------------------------------------------------
  // Directed vector table (thr_hi=8, thr_lo=4)
  // ------------------------------------------------------------------------
  typedef struct {
    bit           r;
    bit           v;
    logic [W-1:0] a;
    bit           ack;
    logic         e_alarm;
    logic         e_rise;
    logic [1:0]   e_state;
    logic [W-1:0] e_peak;
    logic [7:0]   e_count;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(bit r, bit v, logic [W-1:0] a, bit ack,
                              logic ea, logic er, logic [1:0] es,
                              logic [W-1:0] ep, logic [7:0] ec);
    vec_t t;
    t.r = r; t.v = v; t.a = a; t.ack = ack;
    t.e_alarm = ea; t.e_rise = er; t.e_state = es; t.e_peak = ep; t.e_count = ec;
    vecs.push_back(t);
  endfunction

  function automatic void build_table();
    // reset for two edges
    add(1, 0, 16'h00, 0,  0, 0, 0, 16'h00, 0);
    add(1, 0, 16'h00, 0,  0, 0, 0, 16'h00, 0);
    // raise on the third hi sample, then peak follows a larger sample
    add(0, 1, 16'h09, 0,  0, 0, 1, 16'h00, 0);
    add(0, 1, 16'h0A, 0,  0, 0, 1, 16'h00, 0);
    add(0, 1, 16'h09, 0,  1, 1, 2, 16'h09, 1);
    add(0, 0, 16'h00, 0,  1, 0, 2, 16'h09, 1);
    add(0, 1, 16'h0C, 0,  1, 0, 2, 16'h0C, 1);
    // sample equal to thr_lo breaks the low run
    add(0, 1, 16'h03, 0,  1, 0, 2, 16'h0C, 1);
    add(0, 1, 16'h04, 0,  1, 0, 2, 16'h0C, 1);
    // clear: three lo samples (sticky build acknowledges on the third)
    add(0, 1, 16'h03, 0,      1, 0, 2, 16'h0C, 1);
    add(0, 1, 16'h02, 0,      1, 0, 2, 16'h0C, 1);
    add(0, 1, 16'h03, STICKY, 0, 0, 3, 16'h0C, 1);
    // holdoff: hi samples ignored, MONITOR after exactly 8 cycles
    for (int i = 0; i < 3; i++) add(0, 1, 16'h0F, 0,  0, 0, 3, 16'h0C, 1);
    for (int i = 0; i < 4; i++) add(0, 0, 16'h00, 0,  0, 0, 3, 16'h0C, 1);
    add(0, 0, 16'h00, 0,  0, 0, 1, 16'h0C, 1);
    // debounce: sample equal to thr_hi resets the run
    add(0, 1, 16'h09, 0,  0, 0, 1, 16'h0C, 1);
    add(0, 1, 16'h09, 0,  0, 0, 1, 16'h0C, 1);
    add(0, 1, 16'h08, 0,  0, 0, 1, 16'h0C, 1);
    add(0, 1, 16'h09, 0,  0, 0, 1, 16'h0C, 1);
    add(0, 1, 16'h09, 0,  0, 0, 1, 16'h0C, 1);
    // gaps of invalid samples keep the run
    for (int i = 0; i < 5; i++) add(0, 0, 16'h09, 0,  0, 0, 1, 16'h0C, 1);
    add(0, 1, 16'h09, 0,  1, 1, 2, 16'h09, 2);
    add(0, 0, 16'h00, 0,  1, 0, 2, 16'h09, 2);
    // clear again and sit out holdoff
    add(0, 1, 16'h01, 0,      1, 0, 2, 16'h09, 2);
    add(0, 1, 16'h01, 0,      1, 0, 2, 16'h09, 2);
    add(0, 1, 16'h01, STICKY, 0, 0, 3, 16'h09, 2);
    for (int i = 0; i < 7; i++) add(0, 0, 16'h00, 0,  0, 0, 3, 16'h09, 2);
    add(0, 0, 16'h00, 0,  0, 0, 1, 16'h09, 2);
    // reset with a run of two pending: run restarts from zero, no pulse
    add(0, 1, 16'h09, 0,  0, 0, 1, 16'h09, 2);
    add(0, 1, 16'h09, 0,  0, 0, 1, 16'h09, 2);
    add(1, 0, 16'h00, 0,  0, 0, 0, 16'h00, 0);
    add(0, 1, 16'h09, 0,  0, 0, 1, 16'h00, 0);
    add(0, 1, 16'h09, 0,  0, 0, 1, 16'h00, 0);
    add(0, 1, 16'h09, 0,  1, 1, 2, 16'h09, 1);
  endfunction

  initial begin
    int exp_count;
    int a_rand;

    rst = 1'b1; avg_valid = 1'b0; avg_in = '0; alarm_ack = 1'b0;
    thr_hi = 16'h0008; thr_lo = 16'h0004;
    @(posedge clk);
    #1;

    // ---------------- directed table ----------------
    build_table();
    foreach (vecs[i]) begin
      drive(vecs[i].r, vecs[i].v, vecs[i].a, vecs[i].ack);
      check_outputs("vec", i, vecs[i].e_alarm, vecs[i].e_rise, vecs[i].e_state,
                    vecs[i].e_peak, vecs[i].e_count);
    end

    // ---------------- saturation: 260 raise/clear/holdoff episodes ----------
    exp_count = 1;
    for (int i = 0; i < 260; i++) begin
      drive(0, 1, 16'h01, 0);
      drive(0, 1, 16'h01, 0);
      drive(0, 1, 16'h01, STICKY);
      repeat (HOLDOFF) drive(0, 0, 16'h00, 0);
      drive(0, 1, 16'h09, 0);
      drive(0, 1, 16'h09, 0);
      drive(0, 1, 16'h09, 0);
      exp_count = (exp_count < 255) ? exp_count + 1 : 255;
      check_outputs("sat_entry", i, 1'b1, 1'b1, 2'd2, 16'h09, 8'(exp_count));
      drive(0, 0, 16'h00, 0);
      check_outputs("sat_after", i, 1'b1, 1'b0, 2'd2, 16'h09, 8'(exp_count));
    end

`ifdef AVG_ALARM_STICKY_EN
    // ---------------- sticky: lo samples do not clear, ack does -----------
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, 16'h01, 0);
      check_outputs("sticky_hold", i, 1'b1, 1'b0, 2'd2, 16'h09, 8'd255);
    end
    drive(0, 1, 16'h01, 1);
    check_outputs("sticky_ack", 0, 1'b0, 1'b0, 2'd3, 16'h09, 8'd255);
`endif

    // ---------------- randomized stimulus vs reference model --------------
    drive(1, 0, 16'h00, 0);
    check_outputs("rand_rst", 0, 1'b0, 1'b0, 2'd0, 16'h00, 8'd0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 31) == 0) begin
        thr_hi = 16'($urandom_range(2, 12));
        thr_lo = 16'($urandom_range(2, 12));
      end
      a_rand = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 65535))
                                            : int'($urandom_range(0, 15));
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
            16'(a_rand), $urandom_range(0, 15) == 0);
      check_outputs("rand", i, m_alarm, m_rise, 2'(m_state), 16'(m_peak), 8'(m_count));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
